ifetch_prefetch_queue: RTL and testbench

// - Instruction prefetch stage directly upstream of Fetch: issues sequential word reads to instruction memory, buffers returned words with their PCs, and presents them to Fetch as a valid/ready stream.
// - Decouples variable memory latency from the pipeline. Redirects (branch/jump/trap/prediction) flush buffered and in-flight words.

---
 rtl/ifetch_prefetch_queue_pkg.sv | 17 +
 rtl/parameters.vh | 11 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/ifetch_prefetch_queue.sv | 121 ++++++++++++
 tb/tb_ifetch_prefetch_queue.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_prefetch_queue_pkg.sv
// Types and helpers shared by the instruction prefetch queue.
package ifetch_prefetch_queue_pkg;

  // One buffered fetch: the word and the PC it was read from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Fetch addresses are always word aligned; low bits of a target are ignored.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/parameters.vh
// Shared global constants for the instruction-side pipeline.
`ifndef PARAMETERS_VH
`define PARAMETERS_VH

// Fetch address after reset.
`define PC_RESET 32'h0000_0000

// Canonical NOP (addi x0, x0, 0), presented when no instruction is available.
`define NOP      32'h0000_0013

`endif

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with synchronous reset and synchronous clear.
// Writes are registered: a pushed word is visible at the head one cycle later.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   vld,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  // Clear wins over any push/pop in the same cycle; pop on empty is ignored.
  assign do_push = push & ~clr;
  assign do_pop  = pop & ~clr & (cnt != '0);

  assign vld   = (cnt != '0);
  assign rdata = mem[rd_ptr];
  assign count = cnt;

  // Pointer and occupancy bookkeeping; DEPTH is a power of 2 so pointers wrap freely.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(do_push && cnt == FULL_CNT));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(pop && !clr && cnt == '0));
`endif

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word reads, buffers returned
// words with their PCs and streams them to Fetch. Redirects flush both the
// buffer and any reads still in flight.
`include "parameters.vh"

module ifetch_prefetch_queue
  import ifetch_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = `PC_RESET
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_instr_vld,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_instr_rdy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW = CW + 1;

  logic [31:0]        fetch_addr;
  logic [31:0]        resp_pc;
  logic [31:0]        redirect_pc;
  logic [OW-1:0]      outstanding;
  logic [OW-1:0]      discard;
  logic [CW-1:0]      count;
  logic [SW-1:0]      credits_used;
  logic               credit_ok;
  logic               issue;
  logic               push;
  logic               pop;
  logic               fifo_vld;
  logic [ENTRY_W-1:0] fifo_rdata;
  fetch_entry_t       head;
  fetch_entry_t       push_entry;

  assign redirect_pc = word_align(i_redirect_pc);

  // Buffered plus in-flight words may never exceed DEPTH, so every returning
  // word is guaranteed a free slot.
  always_comb begin
    credits_used = SW'(count) + SW'(outstanding);
    credit_ok    = (credits_used < SW'(DEPTH)) &&
                   (outstanding < OW'(MAX_OUTSTANDING));
  end

  assign o_mem_req  = ~rst & ~i_redirect & credit_ok;
  assign o_mem_addr = fetch_addr;
  assign issue      = o_mem_req & i_mem_gnt;

  // Words still owed to a pre-redirect stream are dropped on return.
  assign push       = i_mem_rvalid & ~i_redirect & (discard == '0);
  assign push_entry = '{pc: resp_pc, instr: i_mem_rdata};
  assign pop        = fifo_vld & i_instr_rdy & ~i_redirect;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .clr   (i_redirect),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (fifo_rdata),
    .vld   (fifo_vld),
    .count (count)
  );

  assign head        = fetch_entry_t'(fifo_rdata);
  assign o_instr_vld = fifo_vld & ~i_redirect;
  assign o_instr     = fifo_vld ? head.instr : `NOP;
  assign o_pc        = fifo_vld ? head.pc    : 32'h0;

  // Fetch/response address tracking and in-flight accounting.
  // On redirect every read still in flight after this cycle belongs to the old
  // stream, so discard becomes the post-cycle outstanding count. That already
  // includes any words a previous redirect was discarding, which is what makes
  // back-to-back redirects accumulate without double counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr  <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + OW'(issue) - OW'(i_mem_rvalid);
      if (i_redirect) begin
        fetch_addr <= redirect_pc;
        resp_pc    <= redirect_pc;
        discard    <= outstanding - OW'(i_mem_rvalid);
      end else begin
        if (issue) fetch_addr <= fetch_addr + 32'd4;
        if (i_mem_rvalid) begin
          if (discard != '0) discard <= discard - OW'(1);
          else               resp_pc <= resp_pc + 32'd4;
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
    !(i_mem_rvalid && outstanding == '0));
  a_discard_le_outstanding: assert property (@(posedge clk) disable iff (rst)
    discard <= outstanding);
`endif

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Directed bench for the instruction prefetch queue with a small in-order
// memory model (one-cycle minimum latency, responses can be held back).
module tb_ifetch_prefetch_queue;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_instr_vld;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_instr_rdy;

  int n_checks = 0;
  int n_pass   = 0;

  bit          rv_en;
  logic [31:0] mem_q[$];
  logic [31:0] gnt_q[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_in[$];

  ifetch_prefetch_queue dut (
    .clk           (clk),
    .rst           (rst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .i_mem_gnt     (i_mem_gnt),
    .i_mem_rvalid  (i_mem_rvalid),
    .i_mem_rdata   (i_mem_rdata),
    .o_instr_vld   (o_instr_vld),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .i_instr_rdy   (i_instr_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] gpc(input int i);
    return (i < got_pc.size()) ? got_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] gin(input int i);
    return (i < got_in.size()) ? got_in[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic drive_mem();
    i_mem_rvalid = rv_en && (mem_q.size() > 0) && !rst;
    i_mem_rdata  = i_mem_rvalid ? (mem_q[0] ^ KEY) : 32'h0;
  endtask

  // One clock: record handshakes seen this cycle, advance, update memory.
  task automatic cycle();
    logic        hs, rv, pp;
    logic [31:0] a;
    #1;
    hs = o_mem_req & i_mem_gnt;
    a  = o_mem_addr;
    rv = i_mem_rvalid;
    pp = o_instr_vld & i_instr_rdy & !rst;
    if (pp) begin
      got_pc.push_back(o_pc);
      got_in.push_back(o_instr);
    end
    @(posedge clk);
    if (rst) mem_q.delete();
    else begin
      if (rv) void'(mem_q.pop_front());
      if (hs) begin
        mem_q.push_back(a);
        gnt_q.push_back(a);
      end
    end
    #1;
    drive_mem();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_redirect = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    got_pc.delete();
    got_in.delete();
    gnt_q.delete();
    drive_mem();
  endtask

  task automatic test_reset();
    rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = 32'h0;
    i_mem_gnt = 1'b1; i_instr_rdy = 1'b0; rv_en = 1'b1;
    drive_mem();
    run(2);
    #1;
    n_checks++; if (o_mem_req !== 1'b0) $display("FAIL reset_req got %h want 0", o_mem_req); else n_pass++;
    n_checks++; if (o_mem_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", o_mem_addr); else n_pass++;
    n_checks++; if (o_instr_vld !== 1'b0) $display("FAIL reset_vld got %h want 0", o_instr_vld); else n_pass++;
    n_checks++; if (o_instr !== NOP) $display("FAIL reset_instr got %h want %h", o_instr, NOP); else n_pass++;
    n_checks++; if (o_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", o_pc); else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    i_mem_gnt = 1'b1; i_instr_rdy = 1'b1; rv_en = 1'b1;
    #1;
    n_checks++; if (o_mem_req !== 1'b1) $display("FAIL stream_first_req got %h want 1", o_mem_req); else n_pass++;
    cycle();
    n_checks++; if (o_instr_vld !== 1'b0) $display("FAIL stream_vld_c1 got %h want 0", o_instr_vld); else n_pass++;
    cycle();
    n_checks++; if (o_instr_vld !== 1'b1) $display("FAIL stream_vld_c2 got %h want 1", o_instr_vld); else n_pass++;
    run(6);
    n_checks++; if (got_pc.size() != 6) $display("FAIL stream_count got %0d want 6", got_pc.size()); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (gpc(i) !== 32'(i*4) || gin(i) !== (32'(i*4) ^ KEY))
        $display("FAIL stream_word%0d got pc %h instr %h want pc %h instr %h",
                 i, gpc(i), gin(i), 32'(i*4), 32'(i*4) ^ KEY);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    i_mem_gnt = 1'b1; i_instr_rdy = 1'b0; rv_en = 1'b1;
    run(12);
    #1;
    n_checks++; if (gnt_q.size() != 4) $display("FAIL bp_grants got %0d want 4", gnt_q.size()); else n_pass++;
    n_checks++; if (o_mem_req !== 1'b0) $display("FAIL bp_req_held got %h want 0", o_mem_req); else n_pass++;
    n_checks++; if (o_instr_vld !== 1'b1 || o_pc !== 32'h0) $display("FAIL bp_head got vld %h pc %h want 1 0", o_instr_vld, o_pc); else n_pass++;
    i_instr_rdy = 1'b1;
    run(8);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (gpc(i) !== 32'(i*4) || gin(i) !== (32'(i*4) ^ KEY))
        $display("FAIL bp_word%0d got pc %h instr %h want pc %h", i, gpc(i), gin(i), 32'(i*4));
      else n_pass++;
    end
    n_checks++;
    if (gnt_q.size() < 5 || gnt_q[4] !== 32'h10) $display("FAIL bp_resume got %0d grants want fifth at 00000010", gnt_q.size());
    else n_pass++;
  endtask

  task automatic test_redirect_flush();
    do_reset();
    i_mem_gnt = 1'b1; i_instr_rdy = 1'b1; rv_en = 1'b0;
    drive_mem();
    run(2);
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0103;
    #1;
    n_checks++; if (o_mem_req !== 1'b0) $display("FAIL rd_req_during got %h want 0", o_mem_req); else n_pass++;
    cycle();
    i_redirect = 1'b0; rv_en = 1'b1;
    drive_mem();
    #1;
    n_checks++; if (o_instr_vld !== 1'b0) $display("FAIL rd_empty_after got %h want 0", o_instr_vld); else n_pass++;
    run(8);
    n_checks++; if (gpc(0) !== 32'h100 || gin(0) !== (32'h100 ^ KEY)) $display("FAIL rd_first got pc %h instr %h want pc 00000100", gpc(0), gin(0)); else n_pass++;
    n_checks++; if (gpc(1) !== 32'h104) $display("FAIL rd_second got pc %h want 00000104", gpc(1)); else n_pass++;
  endtask

  task automatic test_redirect_with_rvalid();
    do_reset();
    i_mem_gnt = 1'b1; i_instr_rdy = 1'b1; rv_en = 1'b1;
    run(3);
    rv_en = 1'b0; drive_mem();
    cycle();
    rv_en = 1'b1; drive_mem();
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0200;
    #1;
    n_checks++; if (i_mem_rvalid !== 1'b1 || o_instr_vld !== 1'b0) $display("FAIL rv_same_cycle got vld %h want 0", o_instr_vld); else n_pass++;
    cycle();
    i_redirect = 1'b0;
    run(8);
    n_checks++; if (gpc(0) !== 32'h0 || gpc(1) !== 32'h4) $display("FAIL rv_before got %h %h want 0 4", gpc(0), gpc(1)); else n_pass++;
    n_checks++; if (gpc(2) !== 32'h200 || gin(2) !== (32'h200 ^ KEY)) $display("FAIL rv_target got pc %h instr %h want pc 00000200", gpc(2), gin(2)); else n_pass++;
  endtask

  task automatic test_stall_and_wrap();
    do_reset();
    i_mem_gnt = 1'b0; i_instr_rdy = 1'b1; rv_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h0)
        $display("FAIL stall_c%0d got req %h addr %h want 1 0", i, o_mem_req, o_mem_addr);
      else n_pass++;
      cycle();
    end
    n_checks++; if (gnt_q.size() != 0) $display("FAIL stall_grants got %0d want 0", gnt_q.size()); else n_pass++;
    i_mem_gnt = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
    cycle();
    i_redirect = 1'b0;
    run(8);
    n_checks++; if (gpc(0) !== 32'hFFFF_FFFC) $display("FAIL wrap_pc0 got %h want fffffffc", gpc(0)); else n_pass++;
    n_checks++; if (gpc(1) !== 32'h0 || gin(1) !== KEY) $display("FAIL wrap_pc1 got pc %h instr %h want 0 %h", gpc(1), gin(1), KEY); else n_pass++;
    n_checks++; if (gpc(2) !== 32'h4) $display("FAIL wrap_pc2 got %h want 00000004", gpc(2)); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_mem_gnt = 1'b1; i_instr_rdy = 1'b1; rv_en = 1'b0;
    drive_mem();
    run(2);
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0300;
    cycle();
    i_redirect_pc = 32'h0000_0400; rv_en = 1'b1;
    drive_mem();
    cycle();
    i_redirect = 1'b0;
    run(8);
    n_checks++; if (gpc(0) !== 32'h400 || gin(0) !== (32'h400 ^ KEY)) $display("FAIL b2b_first got pc %h instr %h want pc 00000400", gpc(0), gin(0)); else n_pass++;
    n_checks++; if (gpc(1) !== 32'h404) $display("FAIL b2b_second got %h want 00000404", gpc(1)); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    i_mem_gnt = 1'b1; i_instr_rdy = 1'b1; rv_en = 1'b0;
    drive_mem();
    run(2);
    rst = 1'b1;
    drive_mem();
    #1;
    n_checks++; if (o_mem_req !== 1'b0) $display("FAIL rst_req_during got %h want 0", o_mem_req); else n_pass++;
    cycle();
    n_checks++; if (o_instr_vld !== 1'b0 || o_mem_addr !== 32'h0) $display("FAIL rst_after got vld %h addr %h want 0 0", o_instr_vld, o_mem_addr); else n_pass++;
    rst = 1'b0; rv_en = 1'b1;
    got_pc.delete(); got_in.delete();
    drive_mem();
    run(8);
    n_checks++; if (gpc(0) !== 32'h0 || gin(0) !== KEY) $display("FAIL rst_restart0 got pc %h instr %h want 0 %h", gpc(0), gin(0), KEY); else n_pass++;
    n_checks++; if (gpc(1) !== 32'h4) $display("FAIL rst_restart1 got %h want 00000004", gpc(1)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_with_rvalid();
    test_stall_and_wrap();
    test_back_to_back();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
